// File: rtl/burst_rd_dma.sv
// burst_rd_dma: Avalon-MM burst read master feeding the capture FIFO.
// Reads [pkt_begin, pkt_end) in bursts of at most MAX_BURST beats.
module burst_rd_dma #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BCNT_W    = 16,
  parameter int SPACE_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_pkt_begin,
  input  logic [ADDR_W-1:0] i_pkt_end,
  input  logic [SPACE_W-1:0] i_fifo_space,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_beats_xfer,
  output logic [DATA_W-1:0] o_fifo_in,
  output logic              o_wr_to_fifo,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_read,
  output logic [BCNT_W-1:0] o_burstcount,
  input  logic [DATA_W-1:0] i_readdata,
  input  logic              i_readdatavalid,
  input  logic              i_waitrequest
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int CW    = (ADDR_W > SPACE_W) ? ADDR_W : SPACE_W;
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] MAXB  = ADDR_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_begin;
  logic [ADDR_W-1:0]   r_end;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_rem;
  logic [BCNT_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_beats;
  logic [DATA_W-1:0]   r_fifo_in;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_address;
  logic                r_read;
  logic [BCNT_W-1:0]   r_burstcount;

  logic [ADDR_W-1:0]   w_blen;
  logic [ADDR_W-1:0]   w_words;
  logic                w_bad;
  logic                w_space_ok;

  assign w_blen     = (r_rem > MAXB) ? MAXB : r_rem;
  assign w_words    = (r_end - r_begin) >> LB;
  assign w_space_ok = CW'(i_fifo_space) >= CW'(w_blen);
  assign w_bad      = (r_end <= r_begin)
                    | (|(r_begin & AMASK))
                    | (|(r_end & AMASK));

  // Job sequencer: validate region, issue bursts, forward beats
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_begin      <= '0;
      r_end        <= '0;
      r_addr       <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_beats      <= '0;
      r_fifo_in    <= '0;
      r_wr         <= 1'b0;
      r_address    <= '0;
      r_read       <= 1'b0;
      r_burstcount <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_wr   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_begin <= i_pkt_begin;
            r_end   <= i_pkt_end;
            r_beats <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_rem   <= w_words;
            r_addr  <= r_begin;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_read) begin
            if (!i_waitrequest) begin
              r_read  <= 1'b0;
              r_addr  <= r_addr + (w_blen << LB);
              r_rem   <= r_rem - w_blen;
              r_cnt   <= BCNT_W'(w_blen);
              r_state <= S_DATA;
            end
          end else if (w_space_ok) begin
            r_read       <= 1'b1;
            r_address    <= r_addr;
            r_burstcount <= BCNT_W'(w_blen);
          end
        end
        S_DATA: begin
          if (i_readdatavalid) begin
            r_fifo_in <= i_readdata;
            r_wr      <= 1'b1;
            r_beats   <= r_beats + ADDR_W'(1);
            r_cnt     <= r_cnt - BCNT_W'(1);
            if (r_cnt == BCNT_W'(1)) begin
              r_state <= (r_rem == '0) ? S_DONE : S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_beats_xfer = r_beats;
  assign o_fifo_in    = r_fifo_in;
  assign o_wr_to_fifo = r_wr;
  assign o_address    = r_address;
  assign o_read       = r_read;
  assign o_burstcount = r_burstcount;

endmodule

// File: tb/tb_burst_rd_dma.sv
// tb_burst_rd_dma: directed vectors plus corner sequences for burst_rd_dma.
// Includes a simple Avalon slave and a FIFO-write monitor.
module tb_burst_rd_dma;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 16;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] pkt_begin;
  logic [AW-1:0] pkt_end;
  logic [SW-1:0] fifo_space;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] beats_xfer;
  logic [DW-1:0] fifo_in;
  logic          wr_to_fifo;
  logic [AW-1:0] address;
  logic          read;
  logic [BW-1:0] burstcount;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;

  always #5 clk = ~clk;

  burst_rd_dma #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16),
    .BCNT_W(BW), .SPACE_W(SW)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_start(start),
    .i_pkt_begin(pkt_begin),
    .i_pkt_end(pkt_end),
    .i_fifo_space(fifo_space),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_beats_xfer(beats_xfer),
    .o_fifo_in(fifo_in),
    .o_wr_to_fifo(wr_to_fifo),
    .o_address(address),
    .o_read(read),
    .o_burstcount(burstcount),
    .i_readdata(readdata),
    .i_readdatavalid(readdatavalid),
    .i_waitrequest(waitrequest)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [15:0] bc;
  } burst_t;

  burst_t      exp_b[$];
  logic [31:0] exp_q[$];

  // Avalon slave: optional stall, data with periodic bubbles
  int          sl_left = 0;
  int          sl_delay = 0;
  int          stall_left = 0;
  int          n_stall = 0;
  int          n_acc = 0;
  int          n_read = 0;
  int          bub = 0;
  bit          was_wait = 0;
  logic [31:0] sl_addr = '0;
  logic [31:0] h_addr = '0;
  logic [15:0] h_bc = '0;

  initial begin
    burst_t b;
    readdatavalid = 1'b0;
    readdata = '0;
    waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      readdatavalid = 1'b0;
      if (sl_left > 0) begin
        if (sl_delay > 0) begin
          sl_delay--;
        end else begin
          bub++;
          if (bub % 5 != 4) begin
            readdatavalid = 1'b1;
            readdata = pat(sl_addr);
            sl_addr += 4;
            sl_left--;
          end
        end
      end
      if (read) n_read++;
      if (was_wait) begin
        chk("hold_addr", address, h_addr);
        chk("hold_bc", burstcount, h_bc);
        chk("hold_read", read, 1);
      end
      if (read && stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
        n_stall++;
        was_wait = 1;
        h_addr = address;
        h_bc = burstcount;
      end else begin
        waitrequest = 1'b0;
        was_wait = 0;
        if (read) begin
          n_acc++;
          chk("one_outstanding", sl_left, 0);
          chk("burst_expected", exp_b.size() != 0, 1);
          if (exp_b.size() != 0) begin
            b = exp_b.pop_front();
            chk("burst_addr", address, b.a);
            chk("burst_bc", burstcount, b.bc);
          end
          sl_left = int'(burstcount);
          sl_addr = address;
          sl_delay = 1;
        end
      end
    end
  end

  // FIFO write monitor
  int  n_wr = 0;
  time last_wr_t = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_to_fifo) begin
        n_wr++;
        last_wr_t = $time;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("fifo_in", fifo_in, exp_q.pop_front());
      end
      if (done || err) chk("done_err_excl", done & err, 0);
    end
  end

  bit exp_bad;
  int exp_words;
  int rd0;

  task automatic start_job(input logic [31:0] b, input logic [31:0] e,
                           input bit xbad, input int xwords);
    logic [31:0] a;
    int rem;
    int bl;
    exp_bad = xbad;
    exp_words = xwords;
    rd0 = n_read;
    for (int i = 0; i < xwords; i++) exp_q.push_back(pat(b + 32'(4 * i)));
    a = b;
    rem = xwords;
    while (rem > 0) begin
      bl = (rem > 16) ? 16 : rem;
      exp_b.push_back('{a: a, bc: 16'(bl)});
      a += 32'(bl * 4);
      rem -= bl;
    end
    @(negedge clk);
    start = 1'b1;
    pkt_begin = b;
    pkt_end = e;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("beats_cleared", beats_xfer, 0);
  endtask

  task automatic finish_job();
    int cyc;
    bit got;
    cyc = 1;
    got = 0;
    while (!got && cyc < 3000) begin
      if (done || err) got = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("job_end_seen", got, 1);
    chk("err", err, exp_bad);
    chk("done", done, !exp_bad);
    if (exp_bad) begin
      chk("err_latency", cyc, 2);
      chk("no_read_on_err", n_read - rd0, 0);
    end else begin
      chk("done_after_last_wr", $time - last_wr_t, 10);
    end
    chk("busy_low", busy, 0);
    chk("beats_xfer", beats_xfer, exp_words);
    chk("fifo_q_drained", exp_q.size(), 0);
    chk("burst_q_drained", exp_b.size(), 0);
    @(negedge clk);
    chk("pulse_1cyc", done | err, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_beats"}, beats_xfer, 0);
    chk({tag, "_fifo_in"}, fifo_in, 0);
    chk({tag, "_wr"}, wr_to_fifo, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_bc"}, burstcount, 0);
  endtask

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          bad;
    int          words;
    int          nb;
  } vec_t;

  vec_t vt[9];

  initial begin
    int a0;
    int w0;
    int s0;
    int k;
    vt[0] = '{32'h1000, 32'h1040, 1'b0, 16, 1};
    vt[1] = '{32'h2000, 32'h2068, 1'b0, 26, 2};
    vt[2] = '{32'h3000, 32'h3004, 1'b0, 1, 1};
    vt[3] = '{32'h4000, 32'h40A0, 1'b0, 40, 3};
    vt[4] = '{32'h1000, 32'h1000, 1'b1, 0, 0};
    vt[5] = '{32'h1040, 32'h1000, 1'b1, 0, 0};
    vt[6] = '{32'h1002, 32'h1040, 1'b1, 0, 0};
    vt[7] = '{32'h1000, 32'h1042, 1'b1, 0, 0};
    vt[8] = '{32'h8000, 32'h8080, 1'b0, 32, 2};

    reset = 1'b1;
    start = 1'b0;
    pkt_begin = '0;
    pkt_end = '0;
    fifo_space = 10'd512;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      a0 = n_acc;
      start_job(vt[i].b, vt[i].e, vt[i].bad, vt[i].words);
      finish_job();
      chk("n_bursts", n_acc - a0, vt[i].nb);
    end

    // FIFO credit gating and waitrequest hold
    fifo_space = 10'd15;
    s0 = n_stall;
    start_job(32'h5000, 32'h5040, 1'b0, 16);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("read_gated", read, 0);
    end
    stall_left = 5;
    fifo_space = 10'd16;
    finish_job();
    chk("stall_cycles", n_stall - s0, 5);
    fifo_space = 10'd512;

    // Reset in DATA, stray beats afterwards, reset beats start
    start_job(32'h6000, 32'h6040, 1'b0, 16);
    k = 0;
    while (n_wr - 0 >= 0 && k < 200 && beats_xfer < 3) begin
      @(negedge clk);
      k++;
    end
    chk("reached_3_beats", beats_xfer >= 3, 1);
    reset = 1'b1;
    start = 1'b1;
    pkt_begin = 32'h9000;
    pkt_end = 32'h9040;
    @(negedge clk);
    exp_q.delete();
    exp_b.delete();
    #1;
    w0 = n_wr;
    chk_zero("midjob_reset");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (sl_left > 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("no_write_after_reset", n_wr - w0, 0);
    chk("stray_beats_ended", sl_left, 0);
    chk_zero("after_stray");
    a0 = n_acc;
    start_job(32'h1000, 32'h1040, 1'b0, 16);
    finish_job();
    chk("clean_job_bursts", n_acc - a0, 1);

    // start while busy is ignored
    a0 = n_acc;
    w0 = n_wr;
    start_job(32'h7000, 32'h7080, 1'b0, 32);
    repeat (8) @(negedge clk);
    start = 1'b1;
    pkt_begin = 32'h0100;
    pkt_end = 32'h0200;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_held", busy, 1);
    chk("bx_unaffected", beats_xfer, n_wr - w0);
    finish_job();
    chk("restart_bursts", n_acc - a0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
